// File: rtl/soft_core_pkg.sv
// Shared types and constants for the core's data-store responder.
// Holds the status encoding, fail codes and the default result-store address/value.
package soft_core_pkg;

    localparam int unsigned STATUS_W    = 2;
    localparam int unsigned FAIL_CODE_W = 3;
    localparam int unsigned WORD_W      = 32;

    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } dmem_status_e;

    localparam logic [FAIL_CODE_W-1:0] FC_NONE       = 3'd0;
    localparam logic [FAIL_CODE_W-1:0] FC_BAD_VALUE  = 3'd1;
    localparam logic [FAIL_CODE_W-1:0] FC_OUT_RANGE  = 3'd2;
    localparam logic [FAIL_CODE_W-1:0] FC_MISALIGNED = 3'd3;
    localparam logic [FAIL_CODE_W-1:0] FC_TIMEOUT    = 3'd4;

    localparam int unsigned DEFAULT_RESULT_ADDR = 84;
    localparam int unsigned DEFAULT_PASS_VALUE  = 7;

    // True when a status value ends the test.
    function automatic logic is_done(input dmem_status_e st);
        return (st == ST_PASS) || (st == ST_FAIL);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with asynchronous read and synchronous write.
// Contents have no reset; a same-cycle read of the written word returns the old value.
module dmem_ram #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_W-1:0]    o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-store responder: word RAM plus a store-driven pass/fail result FSM.
// Optional watchdog timeout enabled by defining DMEM_WATCHDOG_EN.
module dmem_responder
    import soft_core_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 6,
    parameter int unsigned RESULT_ADDR    = DEFAULT_RESULT_ADDR,
    parameter int unsigned PASS_VALUE     = DEFAULT_PASS_VALUE,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [WORD_W-1:0]      dataadr,
    input  logic [WORD_W-1:0]      writedata,
    output logic [WORD_W-1:0]      readdata,
    output logic [STATUS_W-1:0]    status,
    output logic                   done,
    output logic [FAIL_CODE_W-1:0] fail_code,
    output logic [CNT_W-1:0]       store_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Address decode
    logic w_misaligned;
    logic w_out_of_range;
    logic w_in_range;
    logic w_is_result;
    logic w_is_pass_data;
    logic w_ram_we;
    logic [ADDR_BITS-1:0] w_word_idx;
    logic [WORD_W-1:0]    w_ram_rdata;

    assign w_misaligned   = |dataadr[1:0];
    assign w_out_of_range = |dataadr[WORD_W-1:ADDR_BITS+2];
    assign w_in_range     = !w_misaligned && !w_out_of_range;
    assign w_is_result    = (dataadr == WORD_W'(RESULT_ADDR));
    assign w_is_pass_data = (writedata == WORD_W'(PASS_VALUE));
    assign w_word_idx     = dataadr[ADDR_BITS+1:2];
    assign w_ram_we       = memwrite && w_in_range;

    dmem_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (WORD_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_word_idx),
        .i_wdata (writedata),
        .i_raddr (w_word_idx),
        .o_rdata (w_ram_rdata)
    );

    assign readdata = w_in_range ? w_ram_rdata : '0;

    // Result FSM state and sticky outputs
    dmem_status_e           r_status;
    dmem_status_e           w_status_nxt;
    logic [FAIL_CODE_W-1:0] r_fail_code;
    logic [FAIL_CODE_W-1:0] w_code_nxt;
    logic                   r_done;
    logic                   w_timeout;

`ifdef DMEM_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] r_wd_cnt;

    // Free-running cycle count while the test is still live
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (!r_done) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign w_timeout = !r_done && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status    <= ST_IDLE;
            r_fail_code <= FC_NONE;
            r_done      <= 1'b0;
        end else begin
            r_status    <= w_status_nxt;
            r_fail_code <= w_code_nxt;
            r_done      <= is_done(w_status_nxt);
        end
    end

    always_comb begin
        w_status_nxt = r_status;
        w_code_nxt   = r_fail_code;
        if (!r_done) begin
            if (memwrite) begin
                if (r_status == ST_IDLE) begin
                    w_status_nxt = ST_RUN;
                end
                if (w_misaligned) begin
                    w_status_nxt = ST_FAIL;
                    w_code_nxt   = FC_MISALIGNED;
                end else if (w_out_of_range) begin
                    w_status_nxt = ST_FAIL;
                    w_code_nxt   = FC_OUT_RANGE;
                end else if (w_is_result) begin
                    if (w_is_pass_data) begin
                        w_status_nxt = ST_PASS;
                    end else begin
                        w_status_nxt = ST_FAIL;
                        w_code_nxt   = FC_BAD_VALUE;
                    end
                end
            end
            // A passing result store in the timeout cycle still wins
            if (w_timeout && (w_status_nxt != ST_PASS)) begin
`ifdef DMEM_WATCHDOG_EN
                w_status_nxt = ST_FAIL;
                w_code_nxt   = FC_TIMEOUT;
`endif
            end
        end
    end

    // Saturating count of stores seen before the test ended
    logic [CNT_W-1:0] r_store_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_store_count <= '0;
        end else if (memwrite && !r_done && (r_store_count != CNT_MAX)) begin
            r_store_count <= r_store_count + CNT_W'(1);
        end
    end

    assign status      = r_status;
    assign done        = r_done;
    assign fail_code   = r_fail_code;
    assign store_count = r_store_count;

endmodule
